logic_thief_drain: RTL
======================

// Module: logic_thief_drain
// PURPOSE
//  Downstream readout engine for the dual-core logic thief trace BRAMs.
//  - Waits for a core's buffer to report full (status bits all ones).
//  - Walks the read address over every entry and captures each 192-bit word.
//  - Emits each word as six 32-bit beats on a valid/ready stream to the
//    software-register/DMA path, core 0 first, then core 1.
// PARAMETERS
//  LT_DATA_WIDTH   192  width of one trace entry (data_i buses)
//  LT_STATUS_BITS  9    top bits of an entry are status; all ones = buffer full
//  LT_LOG2_DEEP    8    log2 of entries per core; entries drained = 2**LT_LOG2_DEEP
//  RD_LAT          2    cycles from addr_o change to valid data_i (1..4)
//  BEAT_WIDTH      32   output beat width; LT_DATA_WIDTH % BEAT_WIDTH == 0
// PORTS
//  clk_i         in   1    system clock
//  reset_n_i     in   1    async active-low reset
//  start_i       in   1    1-cycle pulse; accepted only in IDLE
//  mask_i        in   2    sampled with start_i; bit n = drain core n
//  force_i       in   1    sampled with start_i; 1 = skip wait for full status
//  clear_i       in   1    sync abort (software cmd 0xDEADDEAD); returns to IDLE
//  core0_data_i  in   192  core 0 trace BRAM port-b data
//  core1_data_i  in   192  core 1 trace BRAM port-b data
//  addr_o        out  32   port-b read address, shared by both BRAMs
//  beat_o        out  32   output beat
//  beat_valid_o  out  1    beat_o valid
//  beat_ready_i  in   1    consumer ready
//  beat_core_o   out  1    core index of current beat
//  beat_last_o   out  1    last beat of last entry of current core
//  busy_o        out  1    high in every state except IDLE
//  done_o        out  1    1-cycle pulse when the whole job completes
// BEHAVIOUR
//  - Reset: FSM=IDLE; addr_o=0; beat_o=0; beat_valid_o=0; beat_core_o=0;
//    beat_last_o=0; busy_o=0; done_o=0; shift register and counters cleared.
//  - States and transitions:
//    IDLE      start_i: latch mask/force, core=lowest set mask bit. mask=00:
//              done_o pulses next cycle, stay IDLE.
//    WAIT_FULL exit to ISSUE once force latched or selected data_i[191:183]
//              is all ones; otherwise wait indefinitely.
//    ISSUE     addr_o <= entry count (zero-extended); latency counter=RD_LAT.
//    LAT       decrement counter; at 0 capture data_i of core into 192b shreg.
//    EMIT      beat_o = shreg[31:0]; on valid&&ready shift right by 32.
//              After beat 6: if entry != 2**LT_LOG2_DEEP-1, entry++ and go
//              ISSUE; else NEXT.
//    NEXT      if core 0 done and mask[1] set: core=1, entry=0, go WAIT_FULL;
//              else DONE.
//    DONE      done_o=1 for one cycle, then IDLE.
//  - beat_o/beat_core_o/beat_last_o are stable while valid&&!ready; valid
//    never drops without a handshake (except clear_i or reset).
//  - Per-entry cost: 1 + RD_LAT + 6 cycles at full ready (9 with RD_LAT=2).
//  - Beat order per entry is LSW first: bits[31:0] ... bits[191:160]. Status
//    bits are passed through unmodified in beat 5.
//  - beat_last_o is asserted on beat 5 of entry 255 only.
//  - Entry counter is LT_LOG2_DEEP+1 bits so the last entry is detected
//    without wrap; addr_o never exceeds 2**LT_LOG2_DEEP-1.
//  - clear_i has priority over all events, including start_i in the same
//    cycle. It forces IDLE with outputs at reset values and no done_o.
//  - start_i while busy is ignored.
//  - Async reset mid-beat drops valid immediately; the consumer discards any
//    partial entry.
// STRUCTURE
//  - logic_thief_pkg: LT_DATA_WIDTH, LT_REAL_WIDTH=183, LT_STATUS_BITS,
//    CMD_RESET=32'hDEADDEAD, CMD_ARM=32'hDEADCAFE, drain state enum localparams.
//  - One sub-module, lt_beat_serializer: load 192b word, stream beats with
//    valid/ready, report last beat. The FSM, address generator and latency
//    counter stay in the top level.
// TESTING
//  1. mask=01, force=1, ready=1, BRAM model with data[n]=n pattern ->
//     1536 beats, entry order 0..255; beat_last on beat 1536; done_o one pulse.
//  2. mask=11, force=0, core1 status goes 0x1FF 100 cycles after core0 ->
//     core0 drained first, WAIT_FULL holds 0 beats, then core1 drained; one done_o.
//  3. ready toggled randomly 50% -> beat values and order identical to test 1;
//     beat_o stable whenever valid && !ready.
//  4. clear_i asserted in EMIT of entry 17 -> next cycle valid=0, busy=0,
//     addr_o=0, no done_o; a later start_i restarts at entry 0.
//  5. mask=00 start -> done_o pulses one cycle later, zero beats.
//     start_i while busy -> ignored.
//  6. reset_n_i low during LAT -> outputs at reset values asynchronously;
//     after release the FSM is in IDLE.

Source files
------------

// File: rtl/logic_thief_pkg.sv
// Shared constants, drain FSM state encoding and a status helper for the logic thief readout path.
// Latency: none (declarations only).
// Backpressure: n/a.
package logic_thief_pkg;

    localparam int LT_DATA_WIDTH  = 192;
    localparam int LT_REAL_WIDTH  = 183;
    localparam int LT_STATUS_BITS = 9;
    localparam int BEAT_WIDTH     = 32;
    localparam int BEATS_PER_WORD = LT_DATA_WIDTH / BEAT_WIDTH;

    // Software command words seen on the register path (clear_i is decoded from CMD_RESET upstream)
    localparam logic [31:0] CMD_RESET = 32'hDEADDEAD;
    localparam logic [31:0] CMD_ARM   = 32'hDEADCAFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FULL,
        ST_ISSUE,
        ST_LAT,
        ST_EMIT,
        ST_NEXT,
        ST_DONE
    } drain_state_t;

    // A trace buffer reports full when every status bit above the real payload is set
    function automatic logic status_full(input logic [LT_DATA_WIDTH-1:LT_REAL_WIDTH] status);
        return &status;
    endfunction

endpackage

// File: rtl/lt_beat_serializer.sv
// Loads one trace word and streams it out LSW first as BEATS_PER_WORD beats.
// Latency: first beat valid the cycle after load; one beat per cycle at full ready.
// Backpressure: beat held stable while beat_vld && !beat_rdy; vld only drops after the final handshake or clr.
module lt_beat_serializer
    import logic_thief_pkg::*;
(
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic [LT_DATA_WIDTH-1:0] word_dat,
    output logic [BEAT_WIDTH-1:0]    beat_dat,
    output logic                     beat_vld,
    input  logic                     beat_rdy,
    output logic                     beat_last
);

    localparam int IDX_W = $clog2(BEATS_PER_WORD);

    logic [LT_DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]         idx;
    logic                     final_beat;

    assign final_beat = (idx == IDX_W'(BEATS_PER_WORD - 1));
    assign beat_dat   = shreg[BEAT_WIDTH-1:0];
    assign beat_last  = beat_vld & final_beat;

    // Shift register advances one beat per accepted handshake; clr discards a partial word
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            shreg    <= '0;
            idx      <= '0;
            beat_vld <= 1'b0;
        end else if (clr) begin
            shreg    <= '0;
            idx      <= '0;
            beat_vld <= 1'b0;
        end else if (load) begin
            shreg    <= word_dat;
            idx      <= '0;
            beat_vld <= 1'b1;
        end else if (beat_vld && beat_rdy) begin
            shreg <= shreg >> BEAT_WIDTH;
            if (final_beat) begin
                beat_vld <= 1'b0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/logic_thief_drain.sv
// Drains both logic thief trace BRAMs (core 0 then core 1) onto a 32-bit valid/ready beat stream.
// Latency: 1 + RD_LAT + 6 cycles per entry at full ready; done_o one cycle after the last beat's NEXT decision.
// Backpressure: beat_ready_i low stalls the serializer; the FSM holds in EMIT until the entry's last beat is taken.
module logic_thief_drain
    import logic_thief_pkg::*;
#(
    parameter int LT_LOG2_DEEP = 8,
    parameter int RD_LAT       = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic [1:0]               mask_i,
    input  logic                     force_i,
    input  logic                     clear_i,
    input  logic [LT_DATA_WIDTH-1:0] core0_data_i,
    input  logic [LT_DATA_WIDTH-1:0] core1_data_i,
    output logic [31:0]              addr_o,
    output logic [BEAT_WIDTH-1:0]    beat_o,
    output logic                     beat_valid_o,
    input  logic                     beat_ready_i,
    output logic                     beat_core_o,
    output logic                     beat_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    // One extra bit so the final entry index is compared without wrapping to zero
    localparam int                ENT_W      = LT_LOG2_DEEP + 1;
    localparam logic [ENT_W-1:0]  LAST_ENTRY = ENT_W'((1 << LT_LOG2_DEEP) - 1);
    localparam int                LAT_W      = 3;

    drain_state_t state, state_nxt;

    logic                     mask_hi;
    logic                     force_r;
    logic                     core;
    logic [ENT_W-1:0]         entry;
    logic [LAT_W-1:0]         lat_cnt;
    logic                     done_zero;
    logic [LT_DATA_WIDTH-1:0] sel_data;
    logic                     ser_load;
    logic                     ser_last;
    logic                     entry_done;

    assign sel_data    = core ? core1_data_i : core0_data_i;
    assign ser_load    = (state == ST_LAT) && (lat_cnt == LAT_W'(1));
    assign entry_done  = ser_last && beat_ready_i;
    assign beat_core_o = core;
    assign beat_last_o = ser_last && (entry == LAST_ENTRY);
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = (state == ST_DONE) || done_zero;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; clear_i overrides every other event
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start_i && (mask_i != 2'b00)) state_nxt = ST_WAIT_FULL;
            ST_WAIT_FULL: if (force_r || status_full(sel_data[LT_DATA_WIDTH-1:LT_REAL_WIDTH])) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_LAT;
            ST_LAT:       if (lat_cnt == LAT_W'(1)) state_nxt = ST_EMIT;
            ST_EMIT:      if (entry_done) state_nxt = (entry == LAST_ENTRY) ? ST_NEXT : ST_ISSUE;
            ST_NEXT:      state_nxt = (!core && mask_hi) ? ST_WAIT_FULL : ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end
    end

    // Job parameters, core/entry walk, read address and latency countdown
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_hi   <= 1'b0;
            force_r   <= 1'b0;
            core      <= 1'b0;
            entry     <= '0;
            lat_cnt   <= '0;
            addr_o    <= '0;
            done_zero <= 1'b0;
        end else if (clear_i) begin
            mask_hi   <= 1'b0;
            force_r   <= 1'b0;
            core      <= 1'b0;
            entry     <= '0;
            lat_cnt   <= '0;
            addr_o    <= '0;
            done_zero <= 1'b0;
        end else begin
            done_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mask_hi   <= mask_i[1];
                        force_r   <= force_i;
                        core      <= (mask_i == 2'b10);
                        entry     <= '0;
                        done_zero <= (mask_i == 2'b00);
                    end
                end
                ST_ISSUE: begin
                    addr_o  <= 32'(entry);
                    lat_cnt <= LAT_W'(RD_LAT);
                end
                ST_LAT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                ST_EMIT: begin
                    if (entry_done && (entry != LAST_ENTRY)) begin
                        entry <= entry + ENT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (!core && mask_hi) begin
                        core  <= 1'b1;
                        entry <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    lt_beat_serializer u_ser (
        .core_clk  (clk_i),
        .arst_n    (reset_n_i),
        .clr       (clear_i),
        .load      (ser_load),
        .word_dat  (sel_data),
        .beat_dat  (beat_o),
        .beat_vld  (beat_valid_o),
        .beat_rdy  (beat_ready_i),
        .beat_last (ser_last)
    );

endmodule
